// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared encodings for the execute stage
package ex_pkg;

  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_AND   = 4'h2;
  localparam logic [3:0] ALU_OR    = 4'h3;
  localparam logic [3:0] ALU_XOR   = 4'h4;
  localparam logic [3:0] ALU_SLL   = 4'h5;
  localparam logic [3:0] ALU_SRL   = 4'h6;
  localparam logic [3:0] ALU_SRA   = 4'h7;
  localparam logic [3:0] ALU_SLT   = 4'h8;
  localparam logic [3:0] ALU_SLTU  = 4'h9;
  localparam logic [3:0] ALU_PASSB = 4'hA;
  localparam logic [3:0] ALU_MUL   = 4'hB;

  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_EXMA = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } ex_state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/stage_ex_if.sv
// rtl/stage_ex_if.sv - ID/EX inputs, hazard controls and EX/MA outputs of the execute stage
interface stage_ex_if #(
  parameter int DW  = 32,
  parameter int RW  = 5,
  parameter int MAW = 2,
  parameter int WBW = 3
);
  logic           i_ex_stall;
  logic           i_ex_flush;
  logic           i_ex_valid;
  logic [3:0]     i_ex_aluop;
  logic           i_ex_op2_imm;
  logic           i_ex_cc_we;
  logic [DW-1:0]  i_ex_rs1_val;
  logic [DW-1:0]  i_ex_rs2_val;
  logic [DW-1:0]  i_ex_imm;
  logic [DW-1:0]  i_ex_pc;
  logic [RW-1:0]  i_ex_rs2_addr;
  logic [RW-1:0]  i_ex_rdst;
  logic [MAW-1:0] i_ex_MA;
  logic [WBW-1:0] i_ex_WB;
  logic [1:0]     i_ex_op1_s;
  logic [1:0]     i_ex_op2_s;
  logic [DW-1:0]  i_ex_fwd_wb;
  logic [DW-1:0]  o_ex_alu_rslt;
  logic [DW-1:0]  o_ex_rs2_val;
  logic [DW-1:0]  o_ex_pc;
  logic [RW-1:0]  o_ex_rs2_addr;
  logic [RW-1:0]  o_ex_rdst;
  logic [MAW-1:0] o_ex_MA;
  logic [WBW-1:0] o_ex_WB;
  logic           o_ex_valid;
  logic [3:0]     o_ex_cc;
  logic           o_ex_busy;

  modport master (
    output i_ex_stall, i_ex_flush, i_ex_valid, i_ex_aluop, i_ex_op2_imm, i_ex_cc_we,
           i_ex_rs1_val, i_ex_rs2_val, i_ex_imm, i_ex_pc, i_ex_rs2_addr, i_ex_rdst,
           i_ex_MA, i_ex_WB, i_ex_op1_s, i_ex_op2_s, i_ex_fwd_wb,
    input  o_ex_alu_rslt, o_ex_rs2_val, o_ex_pc, o_ex_rs2_addr, o_ex_rdst,
           o_ex_MA, o_ex_WB, o_ex_valid, o_ex_cc, o_ex_busy
  );

  modport slave (
    input  i_ex_stall, i_ex_flush, i_ex_valid, i_ex_aluop, i_ex_op2_imm, i_ex_cc_we,
           i_ex_rs1_val, i_ex_rs2_val, i_ex_imm, i_ex_pc, i_ex_rs2_addr, i_ex_rdst,
           i_ex_MA, i_ex_WB, i_ex_op1_s, i_ex_op2_s, i_ex_fwd_wb,
    output o_ex_alu_rslt, o_ex_rs2_val, o_ex_pc, o_ex_rs2_addr, o_ex_rdst,
           o_ex_MA, o_ex_WB, o_ex_valid, o_ex_cc, o_ex_busy
  );
endinterface

// File: rtl/ex_mul_iter.sv
// rtl/ex_mul_iter.sv - radix-2 shift-add multiplier, one partial product per step
module ex_mul_iter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic         step_i,
  input  logic         abort_i,
  input  logic [W-1:0] op_a_i,
  input  logic [W-1:0] op_b_i,
  output logic [W-1:0] prod_o,
  output logic         last_o
);
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] mcand_q, mcand_d;
  logic [W-1:0] mplier_q, mplier_d;
  logic [5:0]   cnt_q, cnt_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (abort_i) begin
      cnt_d = '0;
    end else if (start_i) begin
      acc_d    = '0;
      mcand_d  = op_a_i;
      mplier_d = op_b_i;
      cnt_d    = '0;
    end else if (step_i) begin
      // bits shifted past W are dropped: only the low word of the product is kept
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign prod_o = acc_q;
  assign last_o = (cnt_q == 6'(W-1));

endmodule

// File: rtl/stage_ex.sv
// rtl/stage_ex.sv - execute stage: forwarding, ALU, iterative multiplier, NZCV and EX/MA register
module stage_ex
  import ex_pkg::*;
#(
  parameter int DW  = 32,
  parameter int RW  = 5,
  parameter int MAW = 2,
  parameter int WBW = 3
) (
  input logic       Clk,
  input logic       Rst,
  stage_ex_if.slave ex
);
  logic [DW-1:0]  op1, rs2f, op2;
  logic [DW-1:0]  alu_rslt, mul_prod;
  logic [DW:0]    add_full, sub_full;
  logic           c_flag, v_flag;
  logic [3:0]     flags;
  logic           busy, mul_req, mul_start, mul_step, mul_abort, mul_last, cc_load;
  ex_state_e      state_q, state_d;

  logic           valid_q;
  logic [DW-1:0]  alu_rslt_q, rs2_val_q, pc_q;
  logic [RW-1:0]  rs2_addr_q, rdst_q;
  logic [MAW-1:0] ma_q;
  logic [WBW-1:0] wb_q;
  logic [3:0]     cc_q;

  always_comb begin
    case (ex.i_ex_op1_s)
      FWD_EXMA: op1 = alu_rslt_q;
      FWD_WB:   op1 = ex.i_ex_fwd_wb;
      FWD_REG:  op1 = ex.i_ex_rs1_val;
      default:  op1 = ex.i_ex_rs1_val;
    endcase
    case (ex.i_ex_op2_s)
      FWD_EXMA: rs2f = alu_rslt_q;
      FWD_WB:   rs2f = ex.i_ex_fwd_wb;
      FWD_REG:  rs2f = ex.i_ex_rs2_val;
      default:  rs2f = ex.i_ex_rs2_val;
    endcase
  end

  assign op2      = ex.i_ex_op2_imm ? ex.i_ex_imm : rs2f;
  assign add_full = {1'b0, op1} + {1'b0, op2};
  assign sub_full = {1'b0, op1} - {1'b0, op2};

  always_comb begin
    alu_rslt = '0;
    c_flag   = 1'b0;
    v_flag   = 1'b0;
    case (ex.i_ex_aluop)
      ALU_ADD: begin
        alu_rslt = add_full[DW-1:0];
        c_flag   = add_full[DW];
        v_flag   = (op1[DW-1] == op2[DW-1]) && (add_full[DW-1] != op1[DW-1]);
      end
      ALU_SUB: begin
        alu_rslt = sub_full[DW-1:0];
        c_flag   = ~sub_full[DW];
        v_flag   = (op1[DW-1] != op2[DW-1]) && (sub_full[DW-1] != op1[DW-1]);
      end
      ALU_AND:   alu_rslt = op1 & op2;
      ALU_OR:    alu_rslt = op1 | op2;
      ALU_XOR:   alu_rslt = op1 ^ op2;
      ALU_SLL:   alu_rslt = op1 << op2[4:0];
      ALU_SRL:   alu_rslt = op1 >> op2[4:0];
      ALU_SRA:   alu_rslt = $unsigned($signed(op1) >>> op2[4:0]);
      ALU_SLT:   alu_rslt = {{(DW-1){1'b0}}, ($signed(op1) < $signed(op2))};
      ALU_SLTU:  alu_rslt = {{(DW-1){1'b0}}, (op1 < op2)};
      ALU_PASSB: alu_rslt = op2;
      ALU_MUL:   alu_rslt = mul_prod;
      default:   alu_rslt = '0;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = alu_rslt[DW-1];
    flags[FLAG_Z] = (alu_rslt == '0);
    flags[FLAG_C] = c_flag;
    flags[FLAG_V] = v_flag;
  end

  assign mul_req   = ex.i_ex_valid && (ex.i_ex_aluop == ALU_MUL) && !ex.i_ex_flush;
  assign mul_abort = ex.i_ex_flush;

  // DONE drops busy so the waiting MUL retires and ID/EX can advance past it
  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mul_req) begin
          busy = 1'b1;
          if (!ex.i_ex_stall) begin
            mul_start = 1'b1;
            state_d   = MUL;
          end
        end
      end
      MUL: begin
        busy = 1'b1;
        if (!ex.i_ex_stall) begin
          mul_step = 1'b1;
          if (mul_last) state_d = DONE;
        end
      end
      DONE: begin
        if (!ex.i_ex_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (ex.i_ex_flush) begin
      state_d   = IDLE;
      mul_start = 1'b0;
      mul_step  = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  ex_mul_iter #(.W(DW)) u_mul (
    .clk_i   (Clk),
    .rst_ni  (Rst),
    .start_i (mul_start),
    .step_i  (mul_step),
    .abort_i (mul_abort),
    .op_a_i  (op1),
    .op_b_i  (op2),
    .prod_o  (mul_prod),
    .last_o  (mul_last)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      valid_q    <= 1'b0;
      alu_rslt_q <= '0;
      rs2_val_q  <= '0;
      pc_q       <= '0;
      rs2_addr_q <= '0;
      rdst_q     <= '0;
      ma_q       <= '0;
      wb_q       <= '0;
    end else if (ex.i_ex_flush) begin
      valid_q <= 1'b0;
      ma_q    <= '0;
      wb_q    <= '0;
    end else if (!ex.i_ex_stall) begin
      if (busy) begin
        valid_q <= 1'b0;
        ma_q    <= '0;
        wb_q    <= '0;
      end else begin
        valid_q    <= ex.i_ex_valid;
        alu_rslt_q <= alu_rslt;
        rs2_val_q  <= rs2f;
        pc_q       <= ex.i_ex_pc;
        rs2_addr_q <= ex.i_ex_rs2_addr;
        rdst_q     <= ex.i_ex_rdst;
        ma_q       <= ex.i_ex_MA;
        wb_q       <= ex.i_ex_WB;
      end
    end
  end

  assign cc_load = ex.i_ex_valid && ex.i_ex_cc_we && !ex.i_ex_stall && !ex.i_ex_flush && !busy;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)         cc_q <= '0;
    else if (cc_load) cc_q <= flags;
  end

  assign ex.o_ex_alu_rslt = alu_rslt_q;
  assign ex.o_ex_rs2_val  = rs2_val_q;
  assign ex.o_ex_pc       = pc_q;
  assign ex.o_ex_rs2_addr = rs2_addr_q;
  assign ex.o_ex_rdst     = rdst_q;
  assign ex.o_ex_MA       = ma_q;
  assign ex.o_ex_WB       = wb_q;
  assign ex.o_ex_valid    = valid_q;
  assign ex.o_ex_cc       = cc_q;
  assign ex.o_ex_busy     = busy;

endmodule

// File: tb/tb_stage_ex.sv
// tb/tb_stage_ex.sv - self-checking bench for stage_ex
module tb_stage_ex;
  import ex_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stage_ex_if #(.DW(32), .RW(5), .MAW(2), .WBW(3)) ex_if ();

  stage_ex #(.DW(32), .RW(5), .MAW(2), .WBW(3)) dut (
    .Clk (clk),
    .Rst (rst_n),
    .ex  (ex_if)
  );

  int nchecks = 0;
  int nerrors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        use_imm;
    logic [31:0] exp_r;
    logic [3:0]  exp_cc;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference ALU: {N,Z,C,V,result} from wide integer arithmetic
  function automatic logic [35:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb, wide;
    logic [31:0] r;
    logic c, v;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'h0: begin
        wide = sa + sb;
        r = 32'(ua + ub);
        c = (ua + ub) > 64'd4294967295;
        v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'h1: begin
        wide = sa - sb;
        r = 32'(ua - ub);
        c = (ua >= ub);
        v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = 32'(ua << b[4:0]);
      4'h6: r = 32'(ua >> b[4:0]);
      4'h7: r = 32'(sa >>> b[4:0]);
      4'h8: r = (sa < sb) ? 32'd1 : 32'd0;
      4'h9: r = (ua < ub) ? 32'd1 : 32'd0;
      4'hA: r = b;
      4'hB: r = 32'(ua * ub);
      default: r = '0;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  function automatic logic [31:0] fsel(input logic [1:0] s, input logic [31:0] reg_v,
                                       input logic [31:0] exma, input logic [31:0] wb);
    if (s == 2'b01) return exma;
    if (s == 2'b10) return wb;
    return reg_v;
  endfunction

  task automatic drive_idle();
    ex_if.i_ex_stall    = 1'b0;
    ex_if.i_ex_flush    = 1'b0;
    ex_if.i_ex_valid    = 1'b0;
    ex_if.i_ex_aluop    = 4'h0;
    ex_if.i_ex_op2_imm  = 1'b0;
    ex_if.i_ex_cc_we    = 1'b0;
    ex_if.i_ex_rs1_val  = '0;
    ex_if.i_ex_rs2_val  = '0;
    ex_if.i_ex_imm      = '0;
    ex_if.i_ex_pc       = '0;
    ex_if.i_ex_rs2_addr = '0;
    ex_if.i_ex_rdst     = '0;
    ex_if.i_ex_MA       = '0;
    ex_if.i_ex_WB       = '0;
    ex_if.i_ex_op1_s    = 2'b00;
    ex_if.i_ex_op2_s    = 2'b00;
    ex_if.i_ex_fwd_wb   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic cc);
    drive_idle();
    ex_if.i_ex_valid   = 1'b1;
    ex_if.i_ex_aluop   = op;
    ex_if.i_ex_rs1_val = a;
    ex_if.i_ex_rs2_val = b;
    ex_if.i_ex_cc_we   = cc;
  endtask

  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int st_at, input int st_len);
    int edges;
    int busy_cycles;
    logic [35:0] exp;
    edges = 0;
    busy_cycles = 0;
    exp = ref_alu(ALU_MUL, a, b);
    drive_idle();
    tick();
    set_alu(ALU_MUL, a, b, 1'b1);
    ex_if.i_ex_rdst = 5'd9;
    ex_if.i_ex_pc   = 32'h400;
    ex_if.i_ex_MA   = 2'b10;
    ex_if.i_ex_WB   = 3'b101;
    while (!ex_if.o_ex_valid && edges < 200) begin
      ex_if.i_ex_stall = (edges >= st_at) && (edges < st_at + st_len);
      if (edges == 1) begin
        ex_if.i_ex_rs1_val = 32'hDEAD_BEEF;
        ex_if.i_ex_rs2_val = 32'h1234_5677;
      end
      #1;
      if (ex_if.o_ex_busy) busy_cycles++;
      tick();
      edges++;
    end
    ex_if.i_ex_stall = 1'b0;
    check({tag, " latency"}, 64'(edges), 64'(34 + st_len));
    check({tag, " busy_cycles"}, 64'(busy_cycles), 64'(33 + st_len));
    check({tag, " product"}, 64'(ex_if.o_ex_alu_rslt), 64'(exp[31:0]));
    check({tag, " rdst_ma_wb"}, {ex_if.o_ex_rdst, ex_if.o_ex_MA, ex_if.o_ex_WB}, {5'd9, 2'b10, 3'b101});
    check({tag, " nzcv"}, 64'(ex_if.o_ex_cc), 64'(exp[35:32]));
    drive_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1);
  end

  initial begin
    int vcount;
    int bcount;

    drive_idle();
    rst_n = 1'b0;
    tick();
    tick();
    check("reset valid", 64'(ex_if.o_ex_valid), 64'd0);
    check("reset rslt", 64'(ex_if.o_ex_alu_rslt), 64'd0);
    check("reset cc", 64'(ex_if.o_ex_cc), 64'd0);
    check("reset busy", 64'(ex_if.o_ex_busy), 64'd0);
    rst_n = 1'b1;

    // Forwarding from EX/MA and from WB
    set_alu(ALU_ADD, 32'd4, 32'd6, 1'b0);
    tick();
    check("fwd prev rslt", 64'(ex_if.o_ex_alu_rslt), 64'd10);
    set_alu(ALU_ADD, 32'd5, 32'd99, 1'b1);
    ex_if.i_ex_op2_s = 2'b01;
    tick();
    check("fwd exma rslt", 64'(ex_if.o_ex_alu_rslt), 64'd15);
    check("fwd exma valid", 64'(ex_if.o_ex_valid), 64'd1);
    check("fwd exma rs2", 64'(ex_if.o_ex_rs2_val), 64'd10);
    check("fwd exma cc", 64'(ex_if.o_ex_cc), 64'd0);
    set_alu(ALU_SUB, 32'd7, 32'd1, 1'b0);
    ex_if.i_ex_op1_s  = 2'b10;
    ex_if.i_ex_fwd_wb = 32'd100;
    tick();
    check("fwd wb rslt", 64'(ex_if.o_ex_alu_rslt), 64'd99);

    tbl.push_back('{ALU_ADD,   32'd5,          32'd10,         1'b0, 32'd15,         4'b0000});
    tbl.push_back('{ALU_SUB,   32'h8000_0000,  32'd1,          1'b0, 32'h7FFF_FFFF,  4'b0011});
    tbl.push_back('{ALU_ADD,   32'hFFFF_FFFF,  32'd1,          1'b0, 32'd0,          4'b0110});
    tbl.push_back('{ALU_ADD,   32'h7FFF_FFFF,  32'd1,          1'b0, 32'h8000_0000,  4'b1001});
    tbl.push_back('{ALU_SUB,   32'd3,          32'd5,          1'b0, 32'hFFFF_FFFE,  4'b1000});
    tbl.push_back('{ALU_SUB,   32'd5,          32'd5,          1'b1, 32'd0,          4'b0110});
    tbl.push_back('{ALU_AND,   32'hF0F0_1234,  32'h0FF0_FFFF,  1'b0, 32'h00F0_1234,  4'b0000});
    tbl.push_back('{ALU_OR,    32'h8000_0000,  32'd1,          1'b0, 32'h8000_0001,  4'b1000});
    tbl.push_back('{ALU_XOR,   32'hAAAA_AAAA,  32'hAAAA_AAAA,  1'b0, 32'd0,          4'b0100});
    tbl.push_back('{ALU_SLL,   32'd1,          32'h23,         1'b1, 32'd8,          4'b0000});
    tbl.push_back('{ALU_SRL,   32'h8000_0000,  32'd31,         1'b0, 32'd1,          4'b0000});
    tbl.push_back('{ALU_SRA,   32'h8000_0000,  32'd4,          1'b1, 32'hF800_0000,  4'b1000});
    tbl.push_back('{ALU_SLT,   32'hFFFF_FFFF,  32'd1,          1'b0, 32'd1,          4'b0000});
    tbl.push_back('{ALU_SLTU,  32'hFFFF_FFFF,  32'd1,          1'b0, 32'd0,          4'b0100});
    tbl.push_back('{ALU_PASSB, 32'd7,          32'h8000_0000,  1'b0, 32'h8000_0000,  4'b1000});
    tbl.push_back('{4'hC,      32'd7,          32'd9,          1'b0, 32'd0,          4'b0100});
    tbl.push_back('{4'hF,      32'hFFFF_FFFF,  32'd9,          1'b1, 32'd0,          4'b0100});

    foreach (tbl[i]) begin
      set_alu(tbl[i].op, tbl[i].a, tbl[i].use_imm ? ~tbl[i].b : tbl[i].b, 1'b1);
      ex_if.i_ex_op2_imm = tbl[i].use_imm;
      ex_if.i_ex_imm     = tbl[i].b;
      tick();
      check($sformatf("vec%0d rslt", i), 64'(ex_if.o_ex_alu_rslt), 64'(tbl[i].exp_r));
      check($sformatf("vec%0d nzcv", i), 64'(ex_if.o_ex_cc), 64'(tbl[i].exp_cc));
    end

    run_mul("mul 7x6", 32'd7, 32'd6, 0, 0);
    run_mul("mul stall", 32'hFFFF_FFFF, 32'd2, 12, 5);
    for (int k = 0; k < 3; k++) begin
      run_mul($sformatf("mul rnd%0d", k), $urandom, $urandom,
              int'($urandom_range(0, 20)), int'($urandom_range(0, 4)));
    end

    // Flush at multiplier step 10
    drive_idle();
    tick();
    set_alu(ALU_MUL, 32'd3, 32'd4, 1'b1);
    for (int c = 0; c < 11; c++) tick();
    ex_if.i_ex_flush = 1'b1;
    tick();
    drive_idle();
    #1;
    check("flush busy", 64'(ex_if.o_ex_busy), 64'd0);
    check("flush valid", 64'(ex_if.o_ex_valid), 64'd0);
    vcount = 0;
    bcount = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (ex_if.o_ex_valid) vcount++;
      if (ex_if.o_ex_busy) bcount++;
    end
    check("flush no writeback", 64'(vcount + bcount), 64'd0);
    set_alu(ALU_ADD, 32'd1, 32'd1, 1'b1);
    tick();
    check("post flush add", {ex_if.o_ex_valid, ex_if.o_ex_alu_rslt}, {1'b1, 32'd2});

    // Stall holds, stall+flush bubbles
    set_alu(ALU_ADD, 32'd2, 32'd3, 1'b1);
    ex_if.i_ex_MA = 2'b11;
    ex_if.i_ex_WB = 3'b111;
    tick();
    check("pre stall", {ex_if.o_ex_valid, ex_if.o_ex_MA, ex_if.o_ex_WB, ex_if.o_ex_alu_rslt},
          {1'b1, 2'b11, 3'b111, 32'd5});
    set_alu(ALU_ADD, 32'd7, 32'd1, 1'b1);
    ex_if.i_ex_stall = 1'b1;
    tick();
    check("stall hold", {ex_if.o_ex_valid, ex_if.o_ex_MA, ex_if.o_ex_alu_rslt, ex_if.o_ex_cc},
          {1'b1, 2'b11, 32'd5, 4'b0000});
    set_alu(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1);
    ex_if.i_ex_stall = 1'b1;
    ex_if.i_ex_flush = 1'b1;
    tick();
    check("stall+flush bubble", {ex_if.o_ex_valid, ex_if.o_ex_MA, ex_if.o_ex_WB}, 64'd0);
    check("stall+flush cc", 64'(ex_if.o_ex_cc), 64'd0);

    // Asynchronous reset in the middle of a multiply
    set_alu(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1);
    tick();
    check("pre reset cc", 64'(ex_if.o_ex_cc), 64'b1001);
    set_alu(ALU_MUL, 32'd9, 32'd9, 1'b1);
    for (int c = 0; c < 5; c++) tick();
    #1;
    drive_idle();
    rst_n = 1'b0;
    #1;
    check("async reset outs", {ex_if.o_ex_valid, ex_if.o_ex_alu_rslt, ex_if.o_ex_pc, ex_if.o_ex_cc},
          64'd0);
    check("async reset busy", 64'(ex_if.o_ex_busy), 64'd0);
    rst_n = 1'b1;
    vcount = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (ex_if.o_ex_valid || ex_if.o_ex_busy) vcount++;
    end
    check("reset abandons mul", 64'(vcount), 64'd0);

    // Randomized single-cycle traffic against the reference model
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    begin
      logic        m_valid;
      logic [31:0] m_rslt, m_rs2, m_pc;
      logic [4:0]  m_rs2a, m_rdst;
      logic [1:0]  m_ma;
      logic [2:0]  m_wb;
      logic [3:0]  m_cc;
      m_valid = 0; m_rslt = 0; m_rs2 = 0; m_pc = 0;
      m_rs2a = 0; m_rdst = 0; m_ma = 0; m_wb = 0; m_cc = 0;
      for (int i = 0; i < 300; i++) begin
        logic [3:0]  op;
        logic [31:0] a, b, opa, rs2v, opb;
        logic [35:0] res;
        op = 4'($urandom_range(0, 15));
        if (op == ALU_MUL) op = ALU_ADD;
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        set_alu(op, a, b, 1'($urandom_range(0, 1)));
        ex_if.i_ex_valid    = ($urandom_range(0, 7) != 0);
        ex_if.i_ex_stall    = ($urandom_range(0, 9) == 0);
        ex_if.i_ex_flush    = ($urandom_range(0, 9) == 0);
        ex_if.i_ex_op2_imm  = 1'($urandom_range(0, 1));
        ex_if.i_ex_imm      = $urandom;
        ex_if.i_ex_op1_s    = 2'($urandom_range(0, 3));
        ex_if.i_ex_op2_s    = 2'($urandom_range(0, 3));
        ex_if.i_ex_fwd_wb   = $urandom;
        ex_if.i_ex_pc       = $urandom;
        ex_if.i_ex_rs2_addr = 5'($urandom);
        ex_if.i_ex_rdst     = 5'($urandom);
        ex_if.i_ex_MA       = 2'($urandom);
        ex_if.i_ex_WB       = 3'($urandom);

        opa  = fsel(ex_if.i_ex_op1_s, a, m_rslt, ex_if.i_ex_fwd_wb);
        rs2v = fsel(ex_if.i_ex_op2_s, b, m_rslt, ex_if.i_ex_fwd_wb);
        opb  = ex_if.i_ex_op2_imm ? ex_if.i_ex_imm : rs2v;
        res  = ref_alu(op, opa, opb);
        if (ex_if.i_ex_valid && ex_if.i_ex_cc_we && !ex_if.i_ex_stall && !ex_if.i_ex_flush)
          m_cc = res[35:32];
        if (ex_if.i_ex_flush) begin
          m_valid = 0; m_ma = 0; m_wb = 0;
        end else if (!ex_if.i_ex_stall) begin
          m_valid = ex_if.i_ex_valid;
          m_rslt  = res[31:0];
          m_rs2   = rs2v;
          m_pc    = ex_if.i_ex_pc;
          m_rs2a  = ex_if.i_ex_rs2_addr;
          m_rdst  = ex_if.i_ex_rdst;
          m_ma    = ex_if.i_ex_MA;
          m_wb    = ex_if.i_ex_WB;
        end
        tick();
        check($sformatf("rnd%0d ctl", i),
              {ex_if.o_ex_valid, ex_if.o_ex_MA, ex_if.o_ex_WB, ex_if.o_ex_rdst, ex_if.o_ex_rs2_addr},
              {m_valid, m_ma, m_wb, m_rdst, m_rs2a});
        check($sformatf("rnd%0d rslt op%0h", i, op), 64'(ex_if.o_ex_alu_rslt), 64'(m_rslt));
        check($sformatf("rnd%0d rs2_pc", i), {ex_if.o_ex_rs2_val, ex_if.o_ex_pc}, {m_rs2, m_pc});
        check($sformatf("rnd%0d nzcv", i), 64'(ex_if.o_ex_cc), 64'(m_cc));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/stage_ex.md
Name: stage_ex

Overview:
Execute stage between decode (ID/EX register) and memory access (stage MA). Contents:
- operand forwarding muxes
- single-cycle ALU
- an iterative 32-cycle multiplier
- condition-code (NZCV) register
- the EX/MA pipeline register, which it owns

Hazard unit supplies forward selects, stall and flush. stage_ex returns busy so the hazard unit can stall upstream.

Parameters:
DW, 32, datapath width
RW, 5, register address width
MAW, 2, memory-access control bundle width
WBW, 3, write-back control bundle width

Ports:
Clk  in  1  clock
Rst  in  1  async reset, active-low
i_ex_stall  in  1  hold EX/MA register and multiplier
i_ex_flush  in  1  bubble EX/MA, abort multiplier
i_ex_valid  in  1  ID/EX holds a real instruction
i_ex_aluop  in  4  ALU operation
i_ex_op2_imm  in  1  OP2 = immediate
i_ex_cc_we  in  1  instruction updates NZCV
i_ex_rs1_val, i_ex_rs2_val, i_ex_imm, i_ex_pc  in  DW  operands, immediate, PC
i_ex_rs2_addr, i_ex_rdst  in  RW  source 2 / destination address
i_ex_MA  in  MAW  memory control, pass-through
i_ex_WB  in  WBW  write-back control, pass-through
i_ex_op1_s, i_ex_op2_s  in  2  forward select: 00 reg, 01 EX/MA ALU result, 10 WB data, 11 reg
i_ex_fwd_wb  in  DW  WB-stage data for forwarding
o_ex_alu_rslt, o_ex_rs2_val, o_ex_pc  out  DW  EX/MA register
o_ex_rs2_addr, o_ex_rdst  out  RW  EX/MA register
o_ex_MA  out  MAW  EX/MA register
o_ex_WB  out  WBW  EX/MA register
o_ex_valid  out  1  EX/MA holds valid instruction
o_ex_cc  out  4  NZCV register
o_ex_busy  out  1  combinational stall request

Behaviour:
- Reset (Rst=0, async): all EX/MA outputs 0, o_ex_cc=0, FSM IDLE, count 0. Reset mid-multiply abandons it; no output.
- Forwarding:
  - op1 = mux(i_ex_op1_s).
  - rs2f = mux(i_ex_op2_s); o_ex_rs2_val takes rs2f.
  - op2 = i_ex_op2_imm ? i_ex_imm : rs2f.
- ALU ops:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA (shift amount op2[4:0])
  - 8 SLT, 9 SLTU (result 0/1)
  - A PASSB
  - B MUL (low DW bits)
  - C-F produce 0
  - Results are modulo 2^DW.
- Flags:
  - N = rslt[DW-1], Z = (rslt==0).
  - C: ADD carry-out; SUB no-borrow (op1>=op2 unsigned); other ops 0.
  - V: signed overflow for ADD/SUB; other ops 0.
- NZCV register: loads at clock edge when i_ex_valid & i_ex_cc_we & !stall & !flush & !busy. For MUL it loads in DONE.
- Non-MUL latency: 1 cycle; EX/MA loads at the next edge.
- EX/MA update priority:
  1. Flush (wins over stall): o_ex_valid=0, o_ex_MA=0, o_ex_WB=0, data don't-care but held.
  2. Stall: all held.
  3. Busy: bubble (valid/MA/WB=0).
  4. Otherwise load.
- Multiplier FSM:
  - IDLE: valid & aluop==MUL & !flush → capture op1/op2 into the sub-module, count=0, go to MUL. o_ex_busy=1 this cycle.
  - MUL: one shift-add step per unstalled cycle; busy=1. After step count==31 go to DONE.
  - DONE: busy=0; EX/MA loads product with the held rdst/PC/controls; go to IDLE. The held MUL in ID/EX must not restart.
  - Stall freezes the FSM and count in every state.
  - Flush in any state → IDLE, no writeback.
- Total MUL latency with no stall: presented at cycle T, product visible on o_ex_alu_rslt after edge T+33; busy high cycles T..T+32.
- Operands are captured at T, so later forwarding-source changes do not affect the product.

Decomposition:
- Package ex_pkg:
  - ALU opcode constants (ALU_ADD..ALU_MUL)
  - forward-select encodings (FWD_REG, FWD_EXMA, FWD_WB)
  - FSM state encoding (IDLE, MUL, DONE)
  - flag bit indices (N=3, Z=2, C=1, V=0)
- Sub-module ex_mul_iter:
  - ports: start, step enable, abort, 32-bit operands, product, last-step flag
  - radix-2 shift-add, 6-bit counter

Test Plan:
- ADD, rs1=5, rs2 forwarded from EX/MA (prev result 10), op1_s=00, op2_s=01 → o_ex_alu_rslt=15 next edge, o_ex_valid=1, NZCV=0000.
- SUB 0x80000000−1, cc_we=1 → result 0x7FFFFFFF, NZCV=0011.
- MUL 7×6, no stall → busy high exactly 33 cycles; o_ex_valid=0 during busy; result 42 with valid=1 at T+33.
- MUL 0xFFFFFFFF×2 with i_ex_stall high 5 cycles mid-operation → result 0xFFFFFFFE at T+38; count frozen during stall.
- Flush at MUL step 10 → FSM IDLE next cycle, busy=0, no valid output. A following ADD 1+1 produces 2 normally.
- Stall and flush together on a valid ADD → o_ex_valid=0, NZCV unchanged. Rst low mid-MUL → all outputs 0 immediately (async), FSM IDLE.
